// File: rtl/store_buffer.sv
// Store buffer between the core load/store port and the L1 data cache.
// Queues stores, drains them on idle core cycles and forwards buffered bytes to loads.
module store_buffer #(
  parameter int unsigned DEPTH_EXP = 3,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 30,
  parameter bit          COALESCE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_en,
  input  logic                  core_we,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [DATA_W/8-1:0]   core_mask,
  input  logic [DATA_W-1:0]     core_wdata,
  output logic                  core_nack,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  cache_en,
  output logic                  cache_we,
  output logic [ADDR_W-1:0]     cache_addr,
  output logic [DATA_W/8-1:0]   cache_mask,
  output logic [DATA_W-1:0]     cache_wdata,
  input  logic                  cache_nack,
  input  logic [DATA_W-1:0]     cache_rdata,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic [DEPTH_EXP:0]    count
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << DEPTH_EXP;
  localparam int unsigned PTR_W = (DEPTH_EXP > 0) ? DEPTH_EXP : 1;
  localparam int unsigned CNT_W = DEPTH_EXP + 1;

  // Entry storage; validity is implied by (age < cnt), so no per-entry valid bits
  logic [ADDR_W-1:0] entAddr [DEPTH];
  logic [NB-1:0]     entMask [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             inFlight;

  // Response register for the previous-cycle core request
  logic              rspLoad;
  logic              rspReject;
  logic [NB-1:0]     rspMask;
  logic [NB-1:0]     rspCover;
  logic [DATA_W-1:0] rspData;

  logic              isStore;
  logic              isLoad;
  logic              full;
  logic [PTR_W-1:0]  youngIdx;
  logic              canCoalesce;
  logic              doCoalesce;
  logic              doAlloc;
  logic              doReject;
  logic              doIssue;
  logic              doPop;
  logic [NB-1:0]     fwdCover;
  logic [DATA_W-1:0] fwdData;

  // Flush is advisory: the core holds off stores until flush_done is high
  logic unusedFlushReq;
  assign unusedFlushReq = flush_req;

  function automatic logic [PTR_W-1:0] wrapIdx(input int unsigned v);
    return PTR_W'(v % DEPTH);
  endfunction

  assign isStore  = core_en & core_we;
  assign isLoad   = core_en & ~core_we;
  assign full     = (cnt == CNT_W'(DEPTH));
  assign youngIdx = wrapIdx(32'(tail) + DEPTH - 32'd1);

  // Only the head can be in flight, so the youngest is busy only when it is the head
  assign canCoalesce = COALESCE && (cnt != '0) && (entAddr[youngIdx] == core_addr)
                       && !(inFlight && (youngIdx == head));

  assign doCoalesce = isStore & canCoalesce;
  assign doAlloc    = isStore & ~canCoalesce & ~full;
  assign doReject   = isStore & ~canCoalesce & full;
  assign doIssue    = ~core_en & (cnt != '0) & ~inFlight;
  assign doPop      = inFlight & ~cache_nack;

  // Walk oldest to youngest so younger matching bytes override older ones
  always_comb begin
    fwdCover = '0;
    fwdData  = '0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      if ((a < 32'(cnt)) && (entAddr[wrapIdx(32'(head) + a)] == core_addr)) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (entMask[wrapIdx(32'(head) + a)][b]) begin
            fwdCover[b]         = 1'b1;
            fwdData[8*b +: 8]   = entData[wrapIdx(32'(head) + a)][8*b +: 8];
          end
        end
      end
    end
  end

  // Cache port: loads pass straight through, drains issue the head entry
  always_comb begin
    cache_en    = 1'b0;
    cache_we    = 1'b0;
    cache_addr  = '0;
    cache_mask  = '0;
    cache_wdata = '0;
    if (!rst) begin
      if (isLoad) begin
        cache_en   = 1'b1;
        cache_addr = core_addr;
        cache_mask = core_mask;
      end else if (doIssue) begin
        cache_en    = 1'b1;
        cache_we    = 1'b1;
        cache_addr  = entAddr[head];
        cache_mask  = entMask[head];
        cache_wdata = entData[head];
      end
    end
  end

  always_comb begin
    core_rdata = '0;
    if (rspLoad) begin
      for (int unsigned b = 0; b < NB; b++) begin
        core_rdata[8*b +: 8] = rspCover[b] ? rspData[8*b +: 8] : cache_rdata[8*b +: 8];
      end
    end
  end

  // A fully forwarded load never needs the cache, so its nack is ignored
  assign core_nack  = rspReject | (rspLoad & ~(&(rspCover | ~rspMask)) & cache_nack);
  assign flush_done = (cnt == '0) & ~inFlight;
  assign count      = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      inFlight  <= 1'b0;
      rspLoad   <= 1'b0;
      rspReject <= 1'b0;
      rspMask   <= '0;
      rspCover  <= '0;
      rspData   <= '0;
    end else begin
      rspLoad   <= isLoad;
      rspReject <= doReject;
      rspMask   <= isLoad ? core_mask : '0;
      rspCover  <= isLoad ? fwdCover : '0;
      rspData   <= isLoad ? fwdData : '0;
      if (doAlloc) begin
        tail <= wrapIdx(32'(tail) + 32'd1);
      end
      if (doPop) begin
        head <= wrapIdx(32'(head) + 32'd1);
      end
      if (doAlloc && !doPop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!doAlloc && doPop) begin
        cnt <= cnt - CNT_W'(1);
      end
      // A write is outstanding for exactly one cycle: it either pops or is retried later
      inFlight <= doIssue;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (doAlloc) begin
        entAddr[tail] <= core_addr;
        entMask[tail] <= core_mask;
        entData[tail] <= core_wdata;
      end else if (doCoalesce) begin
        entMask[youngIdx] <= entMask[youngIdx] | core_mask;
        for (int unsigned b = 0; b < NB; b++) begin
          if (core_mask[b]) begin
            entData[youngIdx][8*b +: 8] <= core_wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: two instances (coalescing on/off) against a list-based model,
// with directed scenarios pinned by literal expectations followed by random traffic.
module tb_store_buffer;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        core_en;
  logic        core_we;
  logic [29:0] core_addr;
  logic [3:0]  core_mask;
  logic [31:0] core_wdata;
  logic        cache_nack;
  logic [31:0] cache_rdata;
  logic        flush_req;

  logic        nack   [2];
  logic [31:0] rdata  [2];
  logic        cen    [2];
  logic        cwe    [2];
  logic [29:0] caddr  [2];
  logic [3:0]  cmask  [2];
  logic [31:0] cwdata [2];
  logic        fdone  [2];
  logic [2:0]  cnt    [2];

  int nErr    = 0;
  int nChecks = 0;

  // Model: index 0 of each list is the oldest entry
  ent_t        mList [2][4];
  int          mCnt  [2];
  bit          mFly  [2];
  bit          pLoad [2];
  bit          pRej  [2];
  logic [3:0]  pMask [2];
  logic [3:0]  pCov  [2];
  logic [31:0] pData [2];

  store_buffer #(.DEPTH_EXP(2), .DATA_W(32), .ADDR_W(30), .COALESCE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .core_en(core_en), .core_we(core_we), .core_addr(core_addr),
    .core_mask(core_mask), .core_wdata(core_wdata), .core_nack(nack[0]), .core_rdata(rdata[0]),
    .cache_en(cen[0]), .cache_we(cwe[0]), .cache_addr(caddr[0]), .cache_mask(cmask[0]),
    .cache_wdata(cwdata[0]), .cache_nack(cache_nack), .cache_rdata(cache_rdata),
    .flush_req(flush_req), .flush_done(fdone[0]), .count(cnt[0])
  );

  store_buffer #(.DEPTH_EXP(2), .DATA_W(32), .ADDR_W(30), .COALESCE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .core_en(core_en), .core_we(core_we), .core_addr(core_addr),
    .core_mask(core_mask), .core_wdata(core_wdata), .core_nack(nack[1]), .core_rdata(rdata[1]),
    .cache_en(cen[1]), .cache_we(cwe[1]), .cache_addr(caddr[1]), .cache_mask(cmask[1]),
    .cache_wdata(cwdata[1]), .cache_nack(cache_nack), .cache_rdata(cache_rdata),
    .flush_req(flush_req), .flush_done(fdone[1]), .count(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  // Compare all outputs of instance k for the current cycle against the model
  task automatic modelCheck(input int k);
    logic [31:0] er;
    logic        en;
    if (rst) return;
    if (core_en && !core_we) begin
      chk("load_cache_en", k, 32'(cen[k]), 32'd1);
      chk("load_cache_we", k, 32'(cwe[k]), 32'd0);
      chk("load_cache_addr", k, 32'(caddr[k]), 32'(core_addr));
      chk("load_cache_mask", k, 32'(cmask[k]), 32'(core_mask));
    end else if (!core_en && mCnt[k] > 0 && !mFly[k]) begin
      chk("drain_cache_en", k, 32'(cen[k]), 32'd1);
      chk("drain_cache_we", k, 32'(cwe[k]), 32'd1);
      chk("drain_cache_addr", k, 32'(caddr[k]), 32'(mList[k][0].addr));
      chk("drain_cache_mask", k, 32'(cmask[k]), 32'(mList[k][0].mask));
      chk("drain_cache_wdata", k, cwdata[k], mList[k][0].data);
    end else begin
      chk("idle_cache_en", k, 32'(cen[k]), 32'd0);
    end
    if (pLoad[k]) begin
      for (int b = 0; b < 4; b++)
        er[b*8 +: 8] = pCov[k][b] ? pData[k][b*8 +: 8] : cache_rdata[b*8 +: 8];
      en = ((pCov[k] & pMask[k]) == pMask[k]) ? 1'b0 : cache_nack;
    end else begin
      er = 32'd0;
      en = pRej[k];
    end
    chk("core_rdata", k, rdata[k], er);
    chk("core_nack", k, 32'(nack[k]), 32'(en));
    chk("count", k, 32'(cnt[k]), 32'(mCnt[k]));
    chk("flush_done", k, 32'(fdone[k]), 32'(mCnt[k] == 0 && !mFly[k]));
  endtask

  // Advance the model of instance k by one cycle using the current inputs
  task automatic modelUpdate(input int k, input bit co);
    int c;
    bit fly;
    bit pop;
    if (rst) begin
      mCnt[k] = 0; mFly[k] = 0; pLoad[k] = 0; pRej[k] = 0;
      return;
    end
    c   = mCnt[k];
    fly = mFly[k];
    pop = fly && !cache_nack;
    pLoad[k] = 0;
    pRej[k]  = 0;
    if (core_en && core_we) begin
      if (co && c > 0 && mList[k][c-1].addr == core_addr && !(fly && c == 1)) begin
        for (int b = 0; b < 4; b++)
          if (core_mask[b]) mList[k][c-1].data[b*8 +: 8] = core_wdata[b*8 +: 8];
        mList[k][c-1].mask = mList[k][c-1].mask | core_mask;
      end else if (c < 4) begin
        mList[k][c] = '{core_addr, core_mask, core_wdata};
        mCnt[k]++;
      end else begin
        pRej[k] = 1;
      end
    end else if (core_en) begin
      pLoad[k] = 1;
      pMask[k] = core_mask;
      pCov[k]  = 4'd0;
      pData[k] = 32'd0;
      for (int a = 0; a < c; a++) begin
        if (mList[k][a].addr == core_addr) begin
          for (int b = 0; b < 4; b++) begin
            if (mList[k][a].mask[b]) begin
              pCov[k][b] = 1'b1;
              pData[k][b*8 +: 8] = mList[k][a].data[b*8 +: 8];
            end
          end
        end
      end
    end
    if (pop) begin
      for (int i = 0; i < 3; i++) mList[k][i] = mList[k][i+1];
      mCnt[k]--;
    end
    mFly[k] = !core_en && c > 0 && !fly;
  endtask

  task automatic step(input bit r, input bit en, input bit we, input logic [29:0] a,
                      input logic [3:0] m, input logic [31:0] d, input bit cn,
                      input logic [31:0] crd);
    @(negedge clk);
    rst = r; core_en = en; core_we = we; core_addr = a; core_mask = m;
    core_wdata = d; cache_nack = cn; cache_rdata = crd;
    #1;
    modelCheck(0);
    modelCheck(1);
    modelUpdate(0, 1'b1);
    modelUpdate(1, 1'b0);
  endtask

  task automatic flushAll();
    int n = 0;
    flush_req = 1'b1;
    while ((mCnt[0] > 0 || mFly[0] || mCnt[1] > 0 || mFly[1]) && n < 60) begin
      step(0, 0, 0, '0, '0, '0, ($urandom_range(0, 3) == 0), $urandom);
      n++;
    end
    step(0, 0, 0, '0, '0, '0, 1'b0, $urandom);
    chk("flush_done_after_drain", 0, 32'(fdone[0]), 32'd1);
    chk("flush_done_after_drain", 1, 32'(fdone[1]), 32'd1);
    flush_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; core_en = 0; core_we = 0; core_addr = '0; core_mask = '0;
    core_wdata = '0; cache_nack = 0; cache_rdata = '0; flush_req = 0;
    for (int k = 0; k < 2; k++) begin
      mCnt[k] = 0; mFly[k] = 0; pLoad[k] = 0; pRej[k] = 0;
    end

    step(1, 0, 0, '0, '0, '0, 0, '0);
    step(1, 0, 0, '0, '0, '0, 0, '0);
    step(0, 0, 0, '0, '0, '0, 1, 32'hDEADBEEF);
    chk("reset_count", 0, 32'(cnt[0]), 32'd0);
    chk("reset_flush_done", 0, 32'(fdone[0]), 32'd1);
    chk("reset_cache_en", 0, 32'(cen[0]), 32'd0);
    chk("reset_core_nack", 0, 32'(nack[0]), 32'd0);
    chk("reset_core_rdata", 0, rdata[0], 32'd0);

    // Fill to capacity, then one store too many
    for (int i = 0; i < 5; i++)
      step(0, 1, 1, 30'(32'h10 + i), 4'hF, $urandom, 0, '0);
    step(0, 1, 0, 30'h50, 4'hF, '0, 0, 32'h0);
    chk("full_reject_nack", 0, 32'(nack[0]), 32'd1);
    chk("full_count", 0, 32'(cnt[0]), 32'd4);
    chk("full_reject_nack", 1, 32'(nack[1]), 32'd1);
    chk("full_count", 1, 32'(cnt[1]), 32'd4);
    flushAll();

    // Coalescing of two half-word stores
    step(0, 1, 1, 30'h20, 4'b0011, 32'h0000BEEF, 0, '0);
    step(0, 1, 1, 30'h20, 4'b1100, 32'hCAFE0000, 0, '0);
    step(0, 1, 0, 30'h20, 4'hF, '0, 0, '0);
    chk("coalesce_count", 0, 32'(cnt[0]), 32'd1);
    chk("no_coalesce_count", 1, 32'(cnt[1]), 32'd2);
    step(0, 0, 0, '0, '0, '0, 1, 32'h99999999);
    chk("coalesce_fwd_rdata", 0, rdata[0], 32'hCAFEBEEF);
    chk("coalesce_fwd_nack", 0, 32'(nack[0]), 32'd0);
    chk("youngest_wins_rdata", 1, rdata[1], 32'hCAFEBEEF);
    chk("coalesced_drain_wdata", 0, cwdata[0], 32'hCAFEBEEF);
    chk("coalesced_drain_mask", 0, 32'(cmask[0]), 32'hF);
    chk("split_drain_mask", 1, 32'(cmask[1]), 32'h3);
    flushAll();

    // Youngest byte wins, full coverage hides cache nack
    step(0, 1, 1, 30'h30, 4'hF, 32'h11111111, 0, '0);
    step(0, 1, 1, 30'h30, 4'b0001, 32'h00000022, 0, '0);
    step(0, 1, 0, 30'h30, 4'hF, '0, 0, '0);
    step(0, 0, 0, '0, '0, '0, 1, 32'h0);
    chk("merge_rdata", 0, rdata[0], 32'h11111122);
    chk("merge_nack", 0, 32'(nack[0]), 32'd0);
    chk("merge_rdata", 1, rdata[1], 32'h11111122);
    flushAll();

    // Partial forward merged with cache data, then nack retry of the drain
    step(0, 1, 1, 30'h40, 4'b0001, 32'h000000AA, 0, '0);
    step(0, 1, 0, 30'h40, 4'hF, '0, 0, '0);
    step(0, 1, 0, 30'h40, 4'hF, '0, 0, 32'h12345678);
    chk("partial_rdata", 0, rdata[0], 32'h123456AA);
    chk("partial_nack", 0, 32'(nack[0]), 32'd0);
    step(0, 0, 0, '0, '0, '0, 1, 32'h12345678);
    chk("partial_nack_cache", 0, 32'(nack[0]), 32'd1);
    chk("partial_rdata2", 0, rdata[0], 32'h123456AA);
    chk("drain_issue_addr", 0, 32'(caddr[0]), 32'h40);
    step(0, 0, 0, '0, '0, '0, 1, '0);
    chk("nacked_write_no_issue", 0, 32'(cen[0]), 32'd0);
    chk("nacked_write_count", 0, 32'(cnt[0]), 32'd1);
    step(0, 0, 0, '0, '0, '0, 0, '0);
    chk("reissue_en", 0, 32'(cen[0]), 32'd1);
    chk("reissue_we", 0, 32'(cwe[0]), 32'd1);
    chk("reissue_addr", 0, 32'(caddr[0]), 32'h40);
    step(0, 0, 0, '0, '0, '0, 0, '0);
    chk("pre_pop_flush_done", 0, 32'(fdone[0]), 32'd0);
    step(0, 0, 0, '0, '0, '0, 0, '0);
    chk("post_pop_count", 0, 32'(cnt[0]), 32'd0);
    chk("post_pop_flush_done", 0, 32'(fdone[0]), 32'd1);

    // Pointer wrap-around with store/drain pairs
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 30'(32'h60 + i), 4'hF, $urandom, 0, '0);
      step(0, 0, 0, '0, '0, '0, 0, '0);
      chk("wrap_order_addr", 0, 32'(caddr[0]), 32'h60 + 32'(i));
      chk("wrap_order_addr", 1, 32'(caddr[1]), 32'h60 + 32'(i));
      step(0, 0, 0, '0, '0, '0, 0, '0);
    end

    // Reset while a write is in flight
    step(0, 1, 1, 30'h80, 4'hF, 32'h1, 0, '0);
    step(0, 1, 1, 30'h81, 4'hF, 32'h2, 0, '0);
    step(0, 0, 0, '0, '0, '0, 0, '0);
    step(1, 0, 0, '0, '0, '0, 0, '0);
    step(0, 0, 0, '0, '0, '0, 0, '0);
    chk("mid_reset_count", 0, 32'(cnt[0]), 32'd0);
    chk("mid_reset_cache_en", 0, 32'(cen[0]), 32'd0);
    chk("mid_reset_flush_done", 0, 32'(fdone[0]), 32'd1);

    // Random traffic over a small address set to exercise forwarding and coalescing
    for (int i = 0; i < 2500; i++) begin
      flush_req = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 6), 1'($urandom),
           30'(32'h70 + $urandom_range(0, 3)), 4'($urandom), $urandom,
           ($urandom_range(0, 3) == 0), $urandom);
      if (i % 200 == 199) flushAll();
    end
    flushAll();

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
